zombie_collision: RTL and testbench

//  Per-frame collision judge between the player sprite and the zombie obstacles.

---
 rtl/zombie_collision.sv | 166 ++++++++++++++++
 tb/tb_zombie_collision.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/zombie_collision.sv
// Per-frame collision judge: snapshots the player on frame_tick, AABB-tests the obstacle stream,
// and manages lives, invulnerability and game_over. Optional frame score counter: COLLIDE_SCORE_EN.
module zombie_collision #(
   parameter int PLAYER_W      = 32,
   parameter int PLAYER_H      = 32,
   parameter int OBS_W         = 16,
   parameter int OBS_H         = 32,
   parameter int MARGIN        = 2,
   parameter int LIVES         = 3,
   parameter int INVULN_FRAMES = 60
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_tick,
   input  logic [9:0]  player_x,
   input  logic [9:0]  player_y,
   input  logic        obs_valid,
   output logic        obs_ready,
   input  logic [9:0]  obs_x,
   input  logic [9:0]  obs_y,
   input  logic        obs_last,
   input  logic        restart,
   output logic        game_over,
   output logic        hit_pulse,
   output logic [1:0]  lives,
   output logic        invuln,
   output logic [15:0] score
);

   localparam logic [10:0] MARGIN_W = 11'(MARGIN);
   localparam logic [10:0] OBS_W_W  = 11'(OBS_W);
   localparam logic [10:0] OBS_H_W  = 11'(OBS_H);
   localparam logic [10:0] PX_FAR_W = 11'(PLAYER_W - MARGIN);
   localparam logic [10:0] PY_FAR_W = 11'(PLAYER_H - MARGIN);
   localparam logic [1:0]  LIVES_W  = 2'(LIVES);
   localparam logic [7:0]  INVULN_W = 8'(INVULN_FRAMES);

   typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, OVER} state_t;

   state_t     state;
   logic [9:0] sx_p0;
   logic [9:0] sy_p0;
   logic       hit_p1;
   logic       vld_p1;
   logic       frame_hit;
   logic [7:0] inv_cnt;
   logic       hs;
   logic       last_hs;
   logic       merged_hit;

   // Strict compares on 11-bit operands: touching edges do not collide and nothing wraps.
   function automatic logic overlap(input logic [9:0] sx, input logic [9:0] sy,
                                    input logic [9:0] ox, input logic [9:0] oy);
      logic [10:0] sxw;
      logic [10:0] syw;
      logic [10:0] oxw;
      logic [10:0] oyw;
      logic        x_ov;
      logic        y_ov;
      sxw  = {1'b0, sx};
      syw  = {1'b0, sy};
      oxw  = {1'b0, ox};
      oyw  = {1'b0, oy};
      x_ov = ((sxw + MARGIN_W) < (oxw + OBS_W_W)) && (oxw < (sxw + PX_FAR_W));
      y_ov = ((syw + MARGIN_W) < (oyw + OBS_H_W)) && (oyw < (syw + PY_FAR_W));
      overlap = x_ov && y_ov;
   endfunction

   assign hs         = obs_valid && obs_ready;
   assign last_hs    = hs && obs_last && (state == SCAN);
   assign merged_hit = frame_hit || (vld_p1 && hit_p1);
   assign invuln     = (inv_cnt != 8'd0);

   // Stage p0: player snapshot, taken on any tick that starts a new scan
   always_ff @(posedge clk) begin
      if (frame_tick && (state == IDLE || (state == SCAN && !last_hs))) begin
         sx_p0 <= player_x;
         sy_p0 <= player_y;
      end
   end

   // Stage p1: registered overlap result for the obstacle handshaked in the previous cycle
   always_ff @(posedge clk) begin
      hit_p1 <= overlap(sx_p0, sy_p0, obs_x, obs_y);
   end

   always_ff @(posedge clk) begin
      if (!reset_n || restart) begin
         state     <= IDLE;
         obs_ready <= 1'b0;
         vld_p1    <= 1'b0;
         frame_hit <= 1'b0;
         inv_cnt   <= 8'd0;
         lives     <= LIVES_W;
         game_over <= 1'b0;
         hit_pulse <= 1'b0;
      end else begin
         hit_pulse <= 1'b0;
         if (frame_tick && inv_cnt != 8'd0)
            inv_cnt <= inv_cnt - 8'd1;
         case (state)
            IDLE: begin
               vld_p1    <= 1'b0;
               obs_ready <= 1'b0;
               if (frame_tick) begin
                  frame_hit <= 1'b0;
                  obs_ready <= 1'b1;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (last_hs) begin
                  vld_p1    <= 1'b1;
                  frame_hit <= merged_hit;
                  obs_ready <= 1'b0;
                  state     <= RESOLVE;
               end else if (frame_tick) begin
                  // Aborted frame: the partial result and anything in flight are dropped.
                  vld_p1    <= 1'b0;
                  frame_hit <= 1'b0;
               end else begin
                  vld_p1    <= hs;
                  frame_hit <= merged_hit;
               end
            end
            RESOLVE: begin
               vld_p1    <= 1'b0;
               frame_hit <= 1'b0;
               state     <= IDLE;
               obs_ready <= 1'b0;
               if (merged_hit && !invuln) begin
                  lives     <= lives - 2'd1;
                  hit_pulse <= 1'b1;
                  inv_cnt   <= INVULN_W;
                  if (lives == 2'd1) begin
                     game_over <= 1'b1;
                     obs_ready <= 1'b1;
                     state     <= OVER;
                  end
               end
            end
            OVER: begin
               vld_p1    <= 1'b0;
               frame_hit <= 1'b0;
               obs_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               obs_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef COLLIDE_SCORE_EN
   always_ff @(posedge clk) begin
      if (!reset_n || restart)
         score <= 16'd0;
      else if (frame_tick && state != OVER && score != 16'hFFFF)
         score <= score + 16'd1;
   end
`else
   assign score = 16'd0;
`endif

endmodule

// File: tb/tb_zombie_collision.sv
// Directed bench for zombie_collision: edges, invulnerability, game over, abort, restart, reset.
module tb_zombie_collision;

   logic        clk;
   logic        reset_n;
   logic        frame_tick;
   logic [9:0]  player_x;
   logic [9:0]  player_y;
   logic        obs_valid;
   logic        obs_ready;
   logic [9:0]  obs_x;
   logic [9:0]  obs_y;
   logic        obs_last;
   logic        restart;
   logic        game_over;
   logic        hit_pulse;
   logic [1:0]  lives;
   logic        invuln;
   logic [15:0] score;

   int checks = 0;
   int errors = 0;

   zombie_collision dut (
      .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
      .player_x(player_x), .player_y(player_y),
      .obs_valid(obs_valid), .obs_ready(obs_ready),
      .obs_x(obs_x), .obs_y(obs_y), .obs_last(obs_last),
      .restart(restart), .game_over(game_over), .hit_pulse(hit_pulse),
      .lives(lives), .invuln(invuln), .score(score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input logic [9:0] px, input logic [9:0] py);
      player_x   = px;
      player_y   = py;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic send(input logic [9:0] ox, input logic [9:0] oy, input logic last, input logic tk);
      int n = 0;
      while (!obs_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!obs_ready) chk("ready_timeout", 32'(obs_ready), 32'd1);
      obs_valid  = 1'b1;
      obs_x      = ox;
      obs_y      = oy;
      obs_last   = last;
      frame_tick = tk;
      @(negedge clk);
      obs_valid  = 1'b0;
      obs_last   = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic frame(input logic [9:0] ox, input logic [9:0] oy, input logic exp_hit, input string tag);
      tick(10'd100, 10'd350);
      send(ox, oy, 1'b1, 1'b0);
      chk({tag, "_early"}, 32'(hit_pulse), 32'd0);
      @(negedge clk);
      chk(tag, 32'(hit_pulse), 32'(exp_hit));
   endtask

   initial begin
      reset_n = 1'b0; frame_tick = 1'b0; restart = 1'b0;
      player_x = '0; player_y = '0;
      obs_valid = 1'b0; obs_x = '0; obs_y = '0; obs_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_game_over", 32'(game_over), 32'd0);
      chk("rst_hit_pulse", 32'(hit_pulse), 32'd0);
      chk("rst_lives", 32'(lives), 32'd3);
      chk("rst_invuln", 32'(invuln), 32'd0);
      chk("rst_obs_ready", 32'(obs_ready), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Right edge touching: ox=130 equals sx+32-2
      frame(10'd130, 10'd350, 1'b0, "edge130");
      chk("edge130_lives", 32'(lives), 32'd3);

      frame(10'd120, 10'd350, 1'b1, "hit1");
      chk("hit1_lives", 32'(lives), 32'd2);
      chk("hit1_invuln", 32'(invuln), 32'd1);
      @(negedge clk);
      chk("hit1_pulse_one_cycle", 32'(hit_pulse), 32'd0);

      // 59 overlapping frames inside the immunity window
      for (int i = 0; i < 59; i++) frame(10'd129, 10'd350, 1'b0, "inv_ignored");
      chk("inv_lives", 32'(lives), 32'd2);
      chk("inv_still", 32'(invuln), 32'd1);

      tick(10'd100, 10'd350);
      chk("inv_cleared", 32'(invuln), 32'd0);
      send(10'd129, 10'd350, 1'b1, 1'b0);
      chk("hit2_early", 32'(hit_pulse), 32'd0);
      @(negedge clk);
      chk("hit2", 32'(hit_pulse), 32'd1);
      chk("hit2_lives", 32'(lives), 32'd1);

      for (int i = 0; i < 60; i++) begin
         tick(10'd100, 10'd350);
         @(negedge clk);
      end
      chk("inv_expired", 32'(invuln), 32'd0);

      // Abort: overlapping non-last, tick right behind it, then a clean last
      send(10'd120, 10'd350, 1'b0, 1'b0);
      tick(10'd100, 10'd350);
      send(10'd500, 10'd0, 1'b1, 1'b0);
      chk("abort_early", 32'(hit_pulse), 32'd0);
      @(negedge clk);
      chk("abort_no_hit", 32'(hit_pulse), 32'd0);
      chk("abort_lives", 32'(lives), 32'd1);

      frame(10'd120, 10'd350, 1'b1, "hit3");
      chk("hit3_lives", 32'(lives), 32'd0);
      chk("hit3_game_over", 32'(game_over), 32'd1);
      chk("over_ready", 32'(obs_ready), 32'd1);
      send(10'd120, 10'd350, 1'b1, 1'b0);
      tick(10'd100, 10'd350);
      repeat (3) @(negedge clk);
      chk("over_sticky", 32'(game_over), 32'd1);
      chk("over_lives", 32'(lives), 32'd0);
      chk("over_no_pulse", 32'(hit_pulse), 32'd0);
      chk("over_still_ready", 32'(obs_ready), 32'd1);

      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_lives", 32'(lives), 32'd3);
      chk("restart_game_over", 32'(game_over), 32'd0);
      chk("restart_invuln", 32'(invuln), 32'd0);
      chk("restart_idle_ready", 32'(obs_ready), 32'd0);
      chk("restart_score", 32'(score), 32'd0);

      for (int i = 0; i < 10; i++) begin
         tick(10'd100, 10'd350);
         @(negedge clk);
      end
`ifdef COLLIDE_SCORE_EN
      chk("score_ten", 32'(score), 32'd10);
`else
      chk("score_tied", 32'(score), 32'd0);
`endif

      // obs_last handshake with a simultaneous tick: the last wins
      send(10'd120, 10'd350, 1'b1, 1'b1);
      chk("same_cycle_early", 32'(hit_pulse), 32'd0);
      @(negedge clk);
      chk("same_cycle_hit", 32'(hit_pulse), 32'd1);
      chk("same_cycle_lives", 32'(lives), 32'd2);
      chk("same_cycle_idle", 32'(obs_ready), 32'd0);

      // Reset mid-scan with an overlapping obstacle in flight
      tick(10'd100, 10'd350);
      send(10'd120, 10'd350, 1'b0, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_lives", 32'(lives), 32'd3);
      chk("midrst_ready", 32'(obs_ready), 32'd0);
      chk("midrst_invuln", 32'(invuln), 32'd0);
      chk("midrst_score", 32'(score), 32'd0);
      frame(10'd500, 10'd0, 1'b0, "post_reset");
      chk("post_reset_lives", 32'(lives), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
